calc_entry_fsm: RTL and testbench

//  Operand-entry and compute stage for the switch/button calculator, feeding the 7-seg display driver.

---
 rtl/calc_entry_fsm.sv | 246 ++++++++++++++++++++++++
 tb/tb_calc_entry_fsm.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_fsm.sv
// ============================================================================
// calc_entry_fsm
// ----------------------------------------------------------------------------
// Operand-entry and compute stage of the switch/button calculator. Feeds the
// 7-segment display driver.
//
// The design has four parts:
//   * It synchronises all asynchronous inputs through two flops.
//   * It debounces the ENTER and MODE buttons into single-cycle press pulses.
//   * It sequences A-entry -> B-entry -> result display.
//   * It computes a 6-bit signed result from A, B and the selected operation.
//
// Ports
//   clk           in   1  system clock, all logic on posedge
//   rst_n         in   1  synchronous active-low reset
//   sw            in   6  signed operand switches (asynchronous)
//   op_sel        in   2  00 add, 01 sub, 10 mul, 11 pass A (asynchronous)
//   btn_enter     in   1  raw ENTER button
//   btn_mode      in   1  raw MODE button
//   data          out  6  value to display: live switches in A/B entry,
//                         latched result in RES
//   display_mode  out  1  0 decimal, 1 hex; toggled by each MODE press
//   overflow      out  1  result in RES fell outside -32..31
//   state         out  2  00 S_A, 01 S_B, 10 S_RES
//
// Build option
//   CALC_SATURATE_EN : when defined, an overflowing result clamps to 31 or -32
//                      instead of wrapping. The overflow flag behaves the
//                      same in both builds.
// ============================================================================
module calc_entry_fsm #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] sw,
    input  logic [1:0] op_sel,
    input  logic       btn_enter,
    input  logic       btn_mode,
    output logic [5:0] data,
    output logic       display_mode,
    output logic       overflow,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_RES = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Two-flop synchronisers (_p0 first flop, _p1 usable synced value)
    // ------------------------------------------------------------------------
    logic [5:0] sw_p0, sw_p1;
    logic [1:0] op_p0, op_p1;
    logic       ent_p0, ent_p1;
    logic       mode_p0, mode_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_p0   <= '0;
            sw_p1   <= '0;
            op_p0   <= '0;
            op_p1   <= '0;
            ent_p0  <= 1'b0;
            ent_p1  <= 1'b0;
            mode_p0 <= 1'b0;
            mode_p1 <= 1'b0;
        end else begin
            sw_p0   <= sw;
            sw_p1   <= sw_p0;
            op_p0   <= op_sel;
            op_p1   <= op_p0;
            ent_p0  <= btn_enter;
            ent_p1  <= ent_p0;
            mode_p0 <= btn_mode;
            mode_p1 <= mode_p0;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce: the counter saturates at CNT_MAX. The pulse is registered on
    // the edge where the counter steps from CNT_PRE to CNT_MAX, so a press
    // held longer than that cannot fire again until the button is released.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] ent_cnt, mode_cnt;
    logic             ent_pulse, mode_pulse;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_cnt    <= '0;
            mode_cnt   <= '0;
            ent_pulse  <= 1'b0;
            mode_pulse <= 1'b0;
        end else begin
            if (ent_p1) begin
                if (ent_cnt != CNT_MAX) begin
                    ent_cnt <= ent_cnt + CNT_W'(1);
                end
            end else begin
                ent_cnt <= '0;
            end
            if (mode_p1) begin
                if (mode_cnt != CNT_MAX) begin
                    mode_cnt <= mode_cnt + CNT_W'(1);
                end
            end else begin
                mode_cnt <= '0;
            end
            ent_pulse  <= ent_p1 && (ent_cnt == CNT_PRE);
            mode_pulse <= mode_p1 && (mode_cnt == CNT_PRE);
        end
    end

    // ------------------------------------------------------------------------
    // Result fitting: wrap to the low 6 bits, or clamp in the saturating build
    // ------------------------------------------------------------------------
    function automatic logic signed [5:0] fit6(input logic signed [11:0] v);
`ifdef CALC_SATURATE_EN
        if (v > 12'sd31) begin
            return 6'b011111;
        end else if (v < -12'sd32) begin
            return 6'b100000;
        end else begin
            return v[5:0];
        end
`else
        return v[5:0];
`endif
    endfunction

    // ------------------------------------------------------------------------
    // Registered FSM state and datapath
    // ------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic signed [5:0] a_q, a_d;
    logic signed [5:0] b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic signed [5:0] res_q, res_d;
    logic              ovf_q, ovf_d;
    logic [5:0]        data_q, data_d;
    logic              mode_q, mode_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

    // ------------------------------------------------------------------------
    // Compute. In S_B the operands come straight from the synced switches and
    // op select, so the result is ready on the capture edge. Outside S_B the
    // held registers feed the datapath. That value is never loaded, but it
    // keeps B/op stable and observable.
    // ------------------------------------------------------------------------
    logic signed [5:0]  b_src;
    logic [1:0]         op_src;
    logic signed [6:0]  a7, b7, sum7, diff7;
    logic signed [11:0] a12, b12, full;
    logic               full_ovf;

    always_comb begin
        b_src  = (state_q == S_B) ? sw_p1 : b_q;
        op_src = (state_q == S_B) ? op_p1 : op_q;
        a7     = {a_q[5], a_q};
        b7     = {b_src[5], b_src};
        sum7   = a7 + b7;
        diff7  = a7 - b7;
        a12    = {{6{a_q[5]}}, a_q};
        b12    = {{6{b_src[5]}}, b_src};
        case (op_src)
            2'b00:   full = {{5{sum7[6]}}, sum7};
            2'b01:   full = {{5{diff7[6]}}, diff7};
            2'b10:   full = a12 * b12;
            default: full = a12;
        endcase
        full_ovf = (full > 12'sd31) || (full < -12'sd32);
    end

    // ------------------------------------------------------------------------
    // Next-state logic. data_d looks at the next state so that the display
    // switches to the result on the same edge that enters S_RES.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        if (ent_pulse) begin
            case (state_q)
                S_A: begin
                    a_d     = sw_p1;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = sw_p1;
                    op_d    = op_p1;
                    res_d   = fit6(full);
                    ovf_d   = full_ovf;
                    state_d = S_RES;
                end
                S_RES: begin
                    a_d     = '0;
                    b_d     = '0;
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_A;
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end
        data_d = (state_d == S_RES) ? res_d : sw_p1;
        mode_d = mode_q ^ mode_pulse;
    end

    assign data         = data_q;
    assign display_mode = mode_q;
    assign overflow     = ovf_q;
    assign state        = state_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// ============================================================================
// tb_calc_entry_fsm
// ----------------------------------------------------------------------------
// Directed bench for calc_entry_fsm with DEBOUNCE_CYCLES=4.
//
// A behavioural model tracks the following:
//   * synchronised inputs, as a two-sample delay;
//   * button high-run lengths, where a press fires when a run reaches 4;
//   * the calculator sequence, using plain integer arithmetic.
//
// Every cycle the bench compares all outputs against the model. Literal
// checks pin the model's expected values.
// ============================================================================
module tb_calc_entry_fsm;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] sw = '0;
    logic [1:0] op_sel = '0;
    logic       btn_enter = 1'b0;
    logic       btn_mode = 1'b0;
    logic [5:0] data;
    logic       display_mode;
    logic       overflow;
    logic [1:0] state;

    calc_entry_fsm #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw           (sw),
        .op_sel       (op_sel),
        .btn_enter    (btn_enter),
        .btn_mode     (btn_mode),
        .data         (data),
        .display_mode (display_mode),
        .overflow     (overflow),
        .state        (state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    int m_sw1, m_sw2, m_op1, m_op2;
    int m_e1, m_e2, m_d1, m_d2;
    int m_elen, m_dlen;
    bit m_ep, m_dp;
    int m_st, m_a, m_b, m_op, m_res, m_data;
    bit m_ovf, m_mode;

    function automatic void calc(input int a, input int b, input int op,
                                 output int res, output bit ovf);
        int full;
        case (op)
            0:       full = a + b;
            1:       full = a - b;
            2:       full = a * b;
            default: full = a;
        endcase
        ovf = (full < -32) || (full > 31);
`ifdef CALC_SATURATE_EN
        res = (full > 31) ? 31 : ((full < -32) ? -32 : full);
`else
        res = ((full + 1056) % 64) - 32;
`endif
    endfunction

    always @(posedge clk) begin
        bit ep_old, dp_old;
        int r;
        bit o;
        if (!rst_n) begin
            m_sw1 = 0; m_sw2 = 0; m_op1 = 0; m_op2 = 0;
            m_e1 = 0; m_e2 = 0; m_d1 = 0; m_d2 = 0;
            m_elen = 0; m_dlen = 0; m_ep = 0; m_dp = 0;
            m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_data = 0;
            m_ovf = 0; m_mode = 0;
        end else begin
            ep_old = m_ep;
            dp_old = m_dp;
            m_elen = (m_e2 != 0) ? m_elen + 1 : 0;
            m_dlen = (m_d2 != 0) ? m_dlen + 1 : 0;
            m_ep = (m_elen == DC);
            m_dp = (m_dlen == DC);
            if (dp_old) m_mode = !m_mode;
            if (ep_old) begin
                case (m_st)
                    0: begin
                        m_a = m_sw2;
                        m_st = 1;
                    end
                    1: begin
                        m_b = m_sw2;
                        m_op = m_op2;
                        calc(m_a, m_b, m_op, r, o);
                        m_res = r;
                        m_ovf = o;
                        m_st = 2;
                    end
                    default: begin
                        m_a = 0; m_b = 0; m_res = 0; m_ovf = 0;
                        m_st = 0;
                    end
                endcase
            end
            m_data = (m_st == 2) ? m_res : m_sw2;
            m_sw2 = m_sw1; m_sw1 = int'($signed(sw));
            m_op2 = m_op1; m_op1 = int'(op_sel);
            m_e2 = m_e1;   m_e1 = int'(btn_enter);
            m_d2 = m_d1;   m_d1 = int'(btn_mode);
        end
    end

    // ------------------------------------------------------------------------
    // Per-cycle compare at the falling edge, plus literal checks
    // ------------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
        tests++;
        if (data !== 6'(m_data) || display_mode !== m_mode ||
            overflow !== m_ovf || state !== 2'(m_st)) begin
            fails++;
            $display("FAIL cycle_model t=%0t: data=%0d/%0d mode=%0b/%0b ovf=%0b/%0b state=%0d/%0d (actual/required)",
                     $time, $signed(data), m_data, display_mode, m_mode,
                     overflow, m_ovf, state, m_st);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        btn_enter = 1'b0;
        btn_mode  = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic press_enter();
        btn_enter = 1'b1;
        repeat (8) step();
        btn_enter = 1'b0;
        repeat (4) step();
    endtask

    task automatic run_calc(input string name, input int a, input int b, input int op,
                            input int exp_data, input int exp_ovf);
        sw = 6'(a);
        repeat (3) step();
        press_enter();
        sw = 6'(b);
        op_sel = 2'(op);
        repeat (3) step();
        press_enter();
        check({name, "_state"}, int'(state), 2);
        check({name, "_data"}, int'($signed(data)), exp_data);
        check({name, "_ovf"}, int'(overflow), exp_ovf);
        sw = 6'd17;
        op_sel = 2'd3;
        repeat (4) step();
        check({name, "_hold"}, int'($signed(data)), exp_data);
        press_enter();
        check({name, "_back"}, int'(state), 0);
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_state", int'(state), 0);
        check("rst_data", int'(data), 0);
        check("rst_mode", int'(display_mode), 0);
        check("rst_ovf", int'(overflow), 0);
        sw = 6'd9;
        repeat (4) step();
        check("live_sw", int'($signed(data)), 9);

        // Clean press: the state moves 7 edges after a raw rise, exactly once
        btn_enter = 1'b1;
        repeat (6) step();
        check("t1_before", int'(state), 0);
        step();
        check("t1_after", int'(state), 1);
        repeat (3) step();
        btn_enter = 1'b0;
        repeat (6) step();
        check("t1_once", int'(state), 1);

        // Bouncy press: only the final stable run counts
        do_reset();
        btn_enter = 1'b1; step();
        btn_enter = 1'b0; step();
        btn_enter = 1'b1; step();
        btn_enter = 1'b0; step();
        btn_enter = 1'b1;
        repeat (4) step();
        check("t2_early", int'(state), 0);
        repeat (2) step();
        check("t2_before", int'(state), 0);
        step();
        check("t2_after", int'(state), 1);
        btn_enter = 1'b0;
        repeat (4) step();

        // Arithmetic
        do_reset();
        run_calc("add_5_m3", 5, -3, 0, 2, 0);
        run_calc("mul_5_m3", 5, -3, 2, -15, 0);
`ifdef CALC_SATURATE_EN
        run_calc("add_31_1", 31, 1, 0, 31, 1);
        run_calc("mul_m32_m1", -32, -1, 2, 31, 1);
        run_calc("sub_m32_1", -32, 1, 1, -32, 1);
`else
        run_calc("add_31_1", 31, 1, 0, -32, 1);
        run_calc("mul_m32_m1", -32, -1, 2, -32, 1);
        run_calc("sub_m32_1", -32, 1, 1, 31, 1);
`endif
        run_calc("pass_m7", -7, 20, 3, -7, 0);

        // MODE alone toggles in S_A
        btn_mode = 1'b1;
        repeat (8) step();
        btn_mode = 1'b0;
        repeat (4) step();
        check("mode_a", int'(display_mode), 1);

        // MODE and ENTER together in S_RES
        sw = 6'd3; op_sel = 2'd0;
        repeat (3) step();
        press_enter();
        sw = 6'd4;
        repeat (3) step();
        press_enter();
        check("t6_res", int'($signed(data)), 7);
        btn_enter = 1'b1;
        btn_mode  = 1'b1;
        repeat (7) step();
        check("t6_state", int'(state), 0);
        check("t6_mode", int'(display_mode), 0);
        btn_enter = 1'b0;
        btn_mode  = 1'b0;
        repeat (4) step();

        // Reset in the middle of B entry
        btn_mode = 1'b1;
        repeat (8) step();
        btn_mode = 1'b0;
        sw = 6'd12;
        repeat (3) step();
        press_enter();
        sw = 6'(-5);
        repeat (4) step();
        check("midb_state", int'(state), 1);
        check("midb_data", int'($signed(data)), -5);
        rst_n = 1'b0;
        step();
        check("rstb_data", int'(data), 0);
        check("rstb_mode", int'(display_mode), 0);
        check("rstb_ovf", int'(overflow), 0);
        check("rstb_state", int'(state), 0);
        rst_n = 1'b1;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
